// File: rtl/rc5_crypt_core.sv
// RC5-W/R block-cipher core: one half-round per cycle against an external synchronous-read S table.
// Optional `RC5_ROUND_OUT_EN adds the oRound port that exposes the current round index.
module rc5_crypt_core #(
    parameter int W = 32,
    parameter int R = 12,
    localparam int ROT_BITS = $clog2(W),
    localparam int T = 2 * (R + 1),
    localparam int T_LENGTH = $clog2(T)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                iStart,
    input  logic                iMode,
    input  logic [W-1:0]        iA,
    input  logic [W-1:0]        iB,
    output logic [T_LENGTH-1:0] oS_address1,
    output logic [T_LENGTH-1:0] oS_address2,
    input  logic [W-1:0]        iS_sub_i1,
    input  logic [W-1:0]        iS_sub_i2,
    output logic [W-1:0]        oA,
    output logic [W-1:0]        oB,
    output logic                oBusy,
`ifdef RC5_ROUND_OUT_EN
    output logic [7:0]          oRound,
`endif
    output logic                oDone
);

    typedef enum logic [2:0] {IDLE, FETCH, WHITEN, RH1, RH2, DONE} state_t;

    state_t        stateReg, stateNext;
    logic          modeReg, modeNext;
    logic [W-1:0]  aReg, aNext;
    logic [W-1:0]  bReg, bNext;
    logic [7:0]    roundReg, roundNext;

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [ROT_BITS-1:0] n);
        logic [2*W-1:0] t;
        t = {x, x} << n;
        return t[2*W-1:W];
    endfunction

    function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [ROT_BITS-1:0] n);
        logic [2*W-1:0] t;
        t = {x, x} >> n;
        return t[W-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            stateReg <= IDLE;
            modeReg  <= 1'b0;
            aReg     <= '0;
            bReg     <= '0;
            roundReg <= '0;
        end else begin
            stateReg <= stateNext;
            modeReg  <= modeNext;
            aReg     <= aNext;
            bReg     <= bNext;
            roundReg <= roundNext;
        end
    end

    // The round index only changes on edges that enter FETCH, so the S addresses
    // derived from it are stable one cycle before RH1/RH2/WHITEN sample the table.
    always_comb begin
        stateNext = stateReg;
        modeNext  = modeReg;
        aNext     = aReg;
        bNext     = bReg;
        roundNext = roundReg;
        unique case (stateReg)
            IDLE: begin
                if (iStart) begin
                    stateNext = FETCH;
                    modeNext  = iMode;
                    aNext     = iA;
                    bNext     = iB;
                    roundNext = iMode ? 8'd0 : 8'(R);
                end
            end
            FETCH: stateNext = (roundReg != 8'd0) ? RH1 : WHITEN;
            RH1: begin
                stateNext = RH2;
                if (modeReg)
                    aNext = rotl(aReg ^ bReg, bReg[ROT_BITS-1:0]) + iS_sub_i1;
                else
                    bNext = rotr(bReg - iS_sub_i2, aReg[ROT_BITS-1:0]) ^ aReg;
            end
            RH2: begin
                if (modeReg) begin
                    bNext = rotl(bReg ^ aReg, aReg[ROT_BITS-1:0]) + iS_sub_i2;
                    if (roundReg == 8'(R)) begin
                        stateNext = DONE;
                    end else begin
                        stateNext = FETCH;
                        roundNext = roundReg + 8'd1;
                    end
                end else begin
                    aNext     = rotr(aReg - iS_sub_i1, bReg[ROT_BITS-1:0]) ^ bReg;
                    stateNext = FETCH;
                    roundNext = roundReg - 8'd1;
                end
            end
            WHITEN: begin
                if (modeReg) begin
                    aNext     = aReg + iS_sub_i1;
                    bNext     = bReg + iS_sub_i2;
                    roundNext = 8'd1;
                    stateNext = FETCH;
                end else begin
                    aNext     = aReg - iS_sub_i1;
                    bNext     = bReg - iS_sub_i2;
                    stateNext = DONE;
                end
            end
            DONE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign oS_address1 = T_LENGTH'({roundReg, 1'b0});
    assign oS_address2 = T_LENGTH'({roundReg, 1'b1});
    assign oA    = aReg;
    assign oB    = bReg;
    assign oBusy = (stateReg != IDLE);
    assign oDone = (stateReg == DONE);
`ifdef RC5_ROUND_OUT_EN
    assign oRound = roundReg;
`endif

endmodule

// File: tb/tb_rc5_crypt_core.sv
// Directed bench for rc5_crypt_core: four instances (W/R = 32/12, 32/1, 16/4, 64/3) each with its own S-table model.
module tb_rc5_crypt_core;

    logic        clk;
    logic        rst;
    logic        st [4];
    logic        md [4];
    logic [63:0] ia [4];
    logic [63:0] ib [4];
    logic [63:0] sTab [4][32];

    wire  [63:0] oaW [4];
    wire  [63:0] obW [4];
    wire  [15:0] a1W [4];
    wire  [15:0] a2W [4];
    wire         busyW [4];
    wire         doneW [4];

    int passCnt = 0;
    int totalCnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g
        localparam int WW = (gi == 2) ? 16 : ((gi == 3) ? 64 : 32);
        localparam int RR = (gi == 1) ? 1 : ((gi == 2) ? 4 : ((gi == 3) ? 3 : 12));
        localparam int TL = $clog2(2 * (RR + 1));
        logic [TL-1:0] a1, a2;
        logic [WW-1:0] s1, s2, oAw, oBw;
        logic          busy, done;

        rc5_crypt_core #(.W(WW), .R(RR)) dut (
            .clk(clk),
            .rst(rst),
            .iStart(st[gi]),
            .iMode(md[gi]),
            .iA(ia[gi][WW-1:0]),
            .iB(ib[gi][WW-1:0]),
            .oS_address1(a1),
            .oS_address2(a2),
            .iS_sub_i1(s1),
            .iS_sub_i2(s2),
            .oA(oAw),
            .oB(oBw),
            .oBusy(busy),
            .oDone(done)
        );

        always_ff @(posedge clk) begin
            s1 <= WW'(sTab[gi][int'(a1)]);
            s2 <= WW'(sTab[gi][int'(a2)]);
        end

        assign oaW[gi]   = 64'(oAw);
        assign obW[gi]   = 64'(oBw);
        assign a1W[gi]   = 16'(a1);
        assign a2W[gi]   = 16'(a2);
        assign busyW[gi] = busy;
        assign doneW[gi] = done;
    end

    function automatic int wOf(int k);
        return (k == 2) ? 16 : ((k == 3) ? 64 : 32);
    endfunction

    function automatic int rOf(int k);
        return (k == 1) ? 1 : ((k == 2) ? 4 : ((k == 3) ? 3 : 12));
    endfunction

    function automatic logic [63:0] msk(int w);
        return (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] rotlM(logic [63:0] x, int n, int w);
        logic [63:0] m;
        m = msk(w);
        x = x & m;
        n = n % w;
        if (n == 0) return x;
        return ((x << n) | (x >> (w - n))) & m;
    endfunction

    function automatic logic [63:0] rotrM(logic [63:0] x, int n, int w);
        logic [63:0] m;
        m = msk(w);
        x = x & m;
        n = n % w;
        if (n == 0) return x;
        return ((x >> n) | (x << (w - n))) & m;
    endfunction

    // Reference RC5 encipher/decipher on 64-bit containers masked to W.
    task automatic encM(int k, logic [63:0] a, logic [63:0] b, output logic [63:0] ea, output logic [63:0] eb);
        int w;
        logic [63:0] m;
        w = wOf(k);
        m = msk(w);
        a = (a + sTab[k][0]) & m;
        b = (b + sTab[k][1]) & m;
        for (int i = 1; i <= rOf(k); i++) begin
            a = (rotlM(a ^ b, int'(b[5:0]), w) + sTab[k][2*i]) & m;
            b = (rotlM(b ^ a, int'(a[5:0]), w) + sTab[k][2*i+1]) & m;
        end
        ea = a;
        eb = b;
    endtask

    task automatic decM(int k, logic [63:0] a, logic [63:0] b, output logic [63:0] da, output logic [63:0] db);
        int w;
        logic [63:0] m;
        w = wOf(k);
        m = msk(w);
        for (int i = rOf(k); i >= 1; i--) begin
            b = rotrM((b - sTab[k][2*i+1]) & m, int'(a[5:0]), w) ^ a;
            a = rotrM((a - sTab[k][2*i]) & m, int'(b[5:0]), w) ^ b;
        end
        da = (a - sTab[k][0]) & m;
        db = (b - sTab[k][1]) & m;
    endtask

    function automatic logic [31:0] rot32(logic [31:0] v, logic [4:0] n);
        logic [63:0] t;
        t = {v, v} << n;
        return t[63:32];
    endfunction

    // RC5-32/12 key schedule for an all-zero 16-byte key into sTab[0].
    task automatic keyExpand();
        logic [31:0] s [26];
        logic [31:0] l [4];
        logic [31:0] x, y, sum;
        int i, j;
        s[0] = 32'hB7E15163;
        for (int t = 1; t < 26; t++) s[t] = s[t-1] + 32'h9E3779B9;
        for (int t = 0; t < 4; t++) l[t] = 32'h0;
        x = 0; y = 0; i = 0; j = 0;
        for (int t = 0; t < 78; t++) begin
            x = rot32(s[i] + x + y, 5'd3);
            s[i] = x;
            sum = x + y;
            y = rot32(l[j] + sum, sum[4:0]);
            l[j] = y;
            i = (i + 1) % 26;
            j = (j + 1) % 4;
        end
        for (int t = 0; t < 26; t++) sTab[0][t] = 64'(s[t]);
    endtask

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    // Called just after a rising edge; the next edge is the accept edge (edge 0).
    task automatic runOp(int k, bit mode, logic [63:0] a, logic [63:0] b,
                         output logic [63:0] ra, output logic [63:0] rb, input bit trig = 1'b0);
        int lat;
        md[k] = mode; ia[k] = a; ib[k] = b; st[k] = 1'b1;
        @(posedge clk); #1;
        st[k] = 1'b0; md[k] = ~mode; ia[k] = '1; ib[k] = '1;
        check("busyAfterAccept", 64'(busyW[k]), 64'd1);
        lat = 0;
        for (int n = 1; n <= 2000; n++) begin
            st[k] = trig && (n == 5 || n == 20);
            @(posedge clk); #1;
            if (doneW[k]) begin
                lat = n;
                break;
            end
        end
        st[k] = 1'b0;
        ra = oaW[k];
        rb = obW[k];
        check("doneLatency", 64'(lat), 64'(3 * rOf(k) + 2));
        $display("op inst=%0d mode=%0d A=%h B=%h -> A=%h B=%h latency=%0d", k, mode, a, b, ra, rb, lat);
        @(posedge clk); #1;
        check("donePulseWidth", 64'(doneW[k]), 64'd0);
        check("busyAfterDone", 64'(busyW[k]), 64'd0);
        check("resultHeldA", oaW[k], ra);
    endtask

    initial begin
        logic [63:0] ra, rb, ea, eb, a, b, da, db;
        int extra, w;

        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            st[k] = 1'b0; md[k] = 1'b0; ia[k] = '0; ib[k] = '0;
            for (int t = 0; t < 32; t++) sTab[k][t] = '0;
        end
        st[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rstA", oaW[0], 64'd0);
        check("rstB", obW[0], 64'd0);
        check("rstAddr1", 64'(a1W[0]), 64'd0);
        check("rstAddr2", 64'(a2W[0]), 64'd1);
        check("rstBusy", 64'(busyW[0]), 64'd0);
        check("rstDone", 64'(doneW[0]), 64'd0);
        st[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;

        // Zero S table, R = 1
        runOp(1, 1'b1, 64'd1, 64'd0, ra, rb);
        check("zeroS_A", ra, 64'h1);
        check("zeroS_B", rb, 64'h2);

        // Published RC5-32/12 zero-key vector
        keyExpand();
        runOp(0, 1'b1, 64'd0, 64'd0, ra, rb);
        check("vecEncA", ra, 64'hEEDBA521);
        check("vecEncB", rb, 64'h6D8F4B15);
        runOp(0, 1'b0, ra, rb, da, db);
        check("vecDecA", da, 64'h0);
        check("vecDecB", db, 64'h0);

        // Rotate-amount boundaries with random S tables
        for (int k = 1; k < 4; k++) begin
            w = wOf(k);
            for (int t = 0; t < 32; t++) sTab[k][t] = {$urandom, $urandom} & msk(w);
            sTab[k][1] = sTab[k][1] & ~64'(w - 1);
            for (int lo = 0; lo < 2; lo++) begin
                a = {$urandom, $urandom} & msk(w);
                b = (({$urandom, $urandom} & ~64'(w - 1)) | 64'(lo * (w - 1))) & msk(w);
                encM(k, a, b, ea, eb);
                runOp(k, 1'b1, a, b, ra, rb);
                check("rotEncA", ra, ea);
                check("rotEncB", rb, eb);
                decM(k, ra, rb, da, db);
                check("modelRoundTripA", da, a);
                runOp(k, 1'b0, ra, rb, da, db);
                check("rotDecA", da, a);
                check("rotDecB", db, b);
            end
        end

        // iStart pulses at edges 5 and 20 while busy must be ignored
        runOp(0, 1'b1, 64'd0, 64'd0, ra, rb, 1'b1);
        check("retrigA", ra, 64'hEEDBA521);
        check("retrigB", rb, 64'h6D8F4B15);
        extra = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (doneW[0]) extra++;
        end
        check("retrigNoExtraDone", 64'(extra), 64'd0);

        // Abort with reset at edge 10, then a fresh request
        md[0] = 1'b1; ia[0] = 64'h12345678; ib[0] = 64'h9ABCDEF0; st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("abortA", oaW[0], 64'd0);
        check("abortB", obW[0], 64'd0);
        check("abortAddr1", 64'(a1W[0]), 64'd0);
        check("abortAddr2", 64'(a2W[0]), 64'd1);
        check("abortBusy", 64'(busyW[0]), 64'd0);
        check("abortDone", 64'(doneW[0]), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        encM(0, 64'h12345678, 64'h9ABCDEF0, ea, eb);
        runOp(0, 1'b1, 64'h12345678, 64'h9ABCDEF0, ra, rb);
        check("afterAbortA", ra, ea);
        check("afterAbortB", rb, eb);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
